// File: rtl/jtag_dtm_pkg.sv
// Shared JTAG DTM types: TAP states, IR codes, DMI opcodes/FSM states and the TAP transition function.
package jtag_dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR,
        TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR,
        TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_state_t;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    typedef enum logic [1:0] {DMI_NOP = 2'd0, DMI_READ = 2'd1, DMI_WRITE = 2'd2, DMI_BUSY = 2'd3} dmi_op_t;
    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_state_t;

    localparam logic [3:0] DTM_VERSION = 4'd1;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap.sv
// Oversampled JTAG TAP: input synchronisers, TCK edge strobes, 16-state TAP FSM and 5-bit IR.
// JTAG_DTM_IDCODE_EN selects the IR reset value (IDCODE when defined, BYPASS otherwise).
module jtag_tap
    import jtag_dtm_pkg::*;
(
    input  logic       iClk,
    input  logic       nRst,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    input  logic       trstn,
    output tap_state_t tap_state,
    output logic       tck_fall,
    output logic       tdi_sync,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic [4:0] ir,
    output logic       ir_lsb
);

`ifdef JTAG_DTM_IDCODE_EN
    localparam logic [4:0] IR_RESET = IR_IDCODE;
`else
    localparam logic [4:0] IR_RESET = IR_BYPASS;
`endif

    logic [3:0] meta, sync;   // {tck, tms, tdi, trstn}
    logic       tck_prev, tck_rise;
    logic [4:0] ir_shift;
    tap_state_t state_next;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            meta     <= 4'b0;
            sync     <= 4'b0;
            tck_prev <= 1'b0;
        end else begin
            meta     <= {tck, tms, tdi, trstn};
            sync     <= meta;
            tck_prev <= sync[3];
        end
    end

    assign tck_rise = sync[3] & ~tck_prev;
    assign tck_fall = ~sync[3] & tck_prev;
    assign tdi_sync = sync[1];

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) tap_state <= TAP_TLR;
        else       tap_state <= state_next;
    end

    always_comb begin
        state_next = tap_state;
        if (tck_rise) state_next = tap_next(tap_state, sync[2]);
        if (!sync[0]) state_next = TAP_TLR;
    end

    assign capture_dr = tck_rise && (tap_state == TAP_CAP_DR);
    assign shift_dr   = tck_rise && (tap_state == TAP_SHIFT_DR);
    assign update_dr  = tck_fall && (tap_state == TAP_UPD_DR);
    assign ir_lsb     = ir_shift[0];

    // IR commits on the falling edge inside Update-IR so the new value is stable for the next scan.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            ir_shift <= 5'b0;
            ir       <= IR_RESET;
        end else if (tap_state == TAP_TLR) begin
            ir <= IR_RESET;
        end else if (tck_rise && tap_state == TAP_CAP_IR) begin
            ir_shift <= 5'b00001;
        end else if (tck_rise && tap_state == TAP_SHIFT_IR) begin
            ir_shift <= {tdi_sync, ir_shift[4:1]};
        end else if (tck_fall && tap_state == TAP_UPD_IR) begin
            ir <= ir_shift;
        end
    end

endmodule

// File: rtl/jtag_dtm.sv
// RISC-V 0.13 JTAG DTM: IDCODE/DTMCS/DMI/BYPASS data registers and the DMI request/response FSM.
// JTAG_DTM_IDCODE_EN enables the IDCODE instruction; without it IR 0x01 behaves as BYPASS.
module jtag_dtm
    import jtag_dtm_pkg::*;
#(
    parameter int          ABITS  = 7,
    parameter logic [31:0] IDCODE = 32'h1E4A_D001
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             iTck,
    input  logic             iTms,
    input  logic             iTdi,
    input  logic             iTrstn,
    output logic             oTdo,
    output logic             oTdoEn,
    output logic             oDmiReqValid,
    input  logic             iDmiReqReady,
    output logic [ABITS-1:0] oDmiReqAddr,
    output logic [31:0]      oDmiReqData,
    output logic [1:0]       oDmiReqOp,
    input  logic             iDmiRespValid,
    output logic             oDmiRespReady,
    input  logic [31:0]      iDmiRespData,
    input  logic [1:0]       iDmiRespOp,
    output logic             oDmiHardReset
);

    localparam int          DRW     = ABITS + 34;
    localparam logic [5:0]  ABITS_F = 6'(ABITS);

    tap_state_t tap_state;
    logic       tck_fall, tdi, capture_dr, shift_dr, update_dr, ir_lsb;
    logic [4:0] ir;

    jtag_tap u_tap (
        .iClk       (iClk),
        .nRst       (nRst),
        .tck        (iTck),
        .tms        (iTms),
        .tdi        (iTdi),
        .trstn      (iTrstn),
        .tap_state  (tap_state),
        .tck_fall   (tck_fall),
        .tdi_sync   (tdi),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .ir         (ir),
        .ir_lsb     (ir_lsb)
    );

    logic sel_idcode, sel_dtmcs, sel_dmi;
`ifdef JTAG_DTM_IDCODE_EN
    assign sel_idcode = (ir == IR_IDCODE);
`else
    assign sel_idcode = 1'b0;
`endif
    assign sel_dtmcs = (ir == IR_DTMCS);
    assign sel_dmi   = (ir == IR_DMI);

    dmi_state_t     state, state_next;
    logic [DRW-1:0] dr_shift, dr_shifted, dr_capture;
    logic [31:0]    resp_data, dtmcs_capture;
    logic [1:0]     sticky, sticky_next;
    logic           busy, in_tlr, dmi_update, dtmcs_update, hard_reset, dmi_reset, start, resp_take;

    assign busy          = (state != DMI_IDLE);
    assign in_tlr        = (tap_state == TAP_TLR);
    assign oTdoEn        = (tap_state == TAP_SHIFT_DR) || (tap_state == TAP_SHIFT_IR);
    assign dmi_update    = update_dr && sel_dmi;
    assign dtmcs_update  = update_dr && sel_dtmcs;
    assign hard_reset    = dtmcs_update && dr_shift[17];
    assign dmi_reset     = dtmcs_update && dr_shift[16];
    assign start         = dmi_update && !busy && (sticky == 2'd0)
                           && ((dr_shift[1:0] == DMI_READ) || (dr_shift[1:0] == DMI_WRITE));
    assign resp_take     = (state == DMI_WAIT) && iDmiRespValid;
    assign oDmiReqValid  = (state == DMI_REQ);
    assign oDmiRespReady = (state == DMI_WAIT);
    assign dtmcs_capture = {14'b0, 3'b000, 3'd1, sticky, ABITS_F, DTM_VERSION};

    always_comb begin
        dr_capture = '0;
        if (sel_dmi)         dr_capture = {oDmiReqAddr, resp_data, busy ? 2'd3 : sticky};
        else if (sel_dtmcs)  dr_capture[31:0] = dtmcs_capture;
        else if (sel_idcode) dr_capture[31:0] = IDCODE;
    end

    // TDI enters at the MSB of whichever register is selected; BYPASS is a single bit.
    always_comb begin
        dr_shifted = dr_shift >> 1;
        if (sel_dmi) begin
            dr_shifted[DRW-1] = tdi;
        end else if (sel_idcode || sel_dtmcs) begin
            dr_shifted[DRW-1:32] = '0;
            dr_shifted[31]       = tdi;
        end else begin
            dr_shifted    = '0;
            dr_shifted[0] = tdi;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            dr_shift      <= '0;
            oTdo          <= 1'b0;
            oDmiHardReset <= 1'b0;
        end else begin
            oDmiHardReset <= hard_reset;
            if (capture_dr)    dr_shift <= dr_capture;
            else if (shift_dr) dr_shift <= dr_shifted;
            if (tck_fall && tap_state == TAP_SHIFT_DR)      oTdo <= dr_shift[0];
            else if (tck_fall && tap_state == TAP_SHIFT_IR) oTdo <= ir_lsb;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) state <= DMI_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DMI_IDLE: if (start)         state_next = DMI_REQ;
            DMI_REQ:  if (iDmiReqReady)  state_next = DMI_WAIT;
            DMI_WAIT: if (iDmiRespValid) state_next = DMI_IDLE;
            default:                     state_next = DMI_IDLE;
        endcase
        if (hard_reset) state_next = DMI_IDLE;
    end

    // Sticky status only ever grows (0 -> 2 -> 3) until an explicit clear.
    always_comb begin
        sticky_next = sticky;
        if (resp_take && iDmiRespOp >= 2'd2 && sticky != 2'd3) sticky_next = 2'd2;
        if ((capture_dr && sel_dmi && busy) || (dmi_update && busy)) sticky_next = 2'd3;
        if (dmi_reset || hard_reset || in_tlr) sticky_next = 2'd0;
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            sticky      <= 2'd0;
            resp_data   <= 32'd0;
            oDmiReqAddr <= '0;
            oDmiReqData <= 32'd0;
            oDmiReqOp   <= 2'd0;
        end else begin
            sticky <= sticky_next;
            if (start) begin
                oDmiReqAddr <= dr_shift[DRW-1:34];
                oDmiReqData <= dr_shift[33:2];
                oDmiReqOp   <= dr_shift[1:0];
            end
            if (resp_take) resp_data <= iDmiRespData;
        end
    end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: table of IR/DR scans plus hand-written DMI sequences.
module tb_jtag_dtm;

    localparam int ABITS = 7;
    localparam int W     = ABITS + 34;

`ifdef JTAG_DTM_IDCODE_EN
    localparam logic [63:0] EXP_ID = 64'h1E4A_D001;
`else
    localparam logic [63:0] EXP_ID = 64'h0;
`endif

    logic             iClk = 1'b0, nRst = 1'b0;
    logic             iTck = 1'b0, iTms = 1'b0, iTdi = 1'b0, iTrstn = 1'b1;
    logic             oTdo, oTdoEn, oDmiReqValid, oDmiRespReady, oDmiHardReset;
    logic             iDmiReqReady = 1'b0, iDmiRespValid = 1'b0;
    logic [ABITS-1:0] oDmiReqAddr;
    logic [31:0]      oDmiReqData;
    logic [1:0]       oDmiReqOp;
    logic [31:0]      iDmiRespData = 32'd0;
    logic [1:0]       iDmiRespOp = 2'd0;

    jtag_dtm dut (
        .iClk          (iClk),
        .nRst          (nRst),
        .iTck          (iTck),
        .iTms          (iTms),
        .iTdi          (iTdi),
        .iTrstn        (iTrstn),
        .oTdo          (oTdo),
        .oTdoEn        (oTdoEn),
        .oDmiReqValid  (oDmiReqValid),
        .iDmiReqReady  (iDmiReqReady),
        .oDmiReqAddr   (oDmiReqAddr),
        .oDmiReqData   (oDmiReqData),
        .oDmiReqOp     (oDmiReqOp),
        .iDmiRespValid (iDmiRespValid),
        .oDmiRespReady (oDmiRespReady),
        .iDmiRespData  (iDmiRespData),
        .iDmiRespOp    (iDmiRespOp),
        .oDmiHardReset (oDmiHardReset)
    );

    always #5 iClk = ~iClk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int total = 0, bad = 0;
    int req_starts = 0, hr_cnt = 0;
    logic valid_prev = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    always @(negedge iClk) begin
        if (oDmiReqValid && !valid_prev) req_starts++;
        valid_prev = oDmiReqValid;
        if (oDmiHardReset) hr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period; returns TDO as seen just before the rising edge.
    task automatic jtag_clk(input logic tms, input logic tdi, output logic tdo);
        iTms = tms;
        iTdi = tdi;
        #50;
        tdo  = oTdo;
        iTck = 1'b1;
        #50;
        iTck = 1'b0;
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = '0;
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        for (int i = 0; i < len; i++) begin
            if (i == 0) check("tdo_en_shift", oTdoEn, 1);
            jtag_clk(i == len - 1, din[i], t);
            dout[i] = t;
        end
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
    endtask

    task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
        logic t;
        dout = '0;
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, din[i], t);
            dout[i] = t;
        end
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [4:0] c;
        scan_ir(v, c);
        check("ir_capture", c, 5'b00001);
    endtask

    function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    task automatic dm_serve(input int delay, input logic [31:0] d, input logic [1:0] op);
        int n = 0;
        @(negedge iClk);
        while (!oDmiReqValid && n < 100) begin
            @(negedge iClk);
            n++;
        end
        check("dm_req_seen", oDmiReqValid, 1);
        repeat (delay) @(negedge iClk);
        check("dm_req_held", oDmiReqValid, 1);
        obs_q.push_back({oDmiReqAddr, oDmiReqData, oDmiReqOp});
        iDmiReqReady = 1'b1;
        @(negedge iClk);
        iDmiReqReady = 1'b0;
        check("dm_resp_ready", oDmiRespReady, 1);
        iDmiRespData  = d;
        iDmiRespOp    = op;
        iDmiRespValid = 1'b1;
        @(negedge iClk);
        iDmiRespValid = 1'b0;
        check("dm_back_idle", oDmiRespReady, 0);
    endtask

    task automatic sb_check(input string name);
        logic [W-1:0] e, g;
        check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            g = obs_q.pop_front();
            e = exp_q.pop_front();
            check(name, 64'(g), 64'(e));
        end
    endtask

    typedef struct {
        logic [4:0]  ir;
        int          len;
        logic [63:0] din;
        logic [63:0] dexp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [63:0] d;
        logic        t;
        int          rs;

        vecs[0] = '{ir: 5'h01, len: 32, din: 64'h0,  dexp: EXP_ID};
        vecs[1] = '{ir: 5'h10, len: 32, din: 64'h0,  dexp: 64'h1071};
        vecs[2] = '{ir: 5'h1F, len: 8,  din: 64'hA5, dexp: 64'h4A};
        vecs[3] = '{ir: 5'h05, len: 4,  din: 64'hF,  dexp: 64'hE};
        vecs[4] = '{ir: 5'h11, len: W,  din: 64'h0,  dexp: 64'h0};

        repeat (3) @(negedge iClk);
        check("rst_tdo", oTdo, 0);
        check("rst_tdo_en", oTdoEn, 0);
        check("rst_req_valid", oDmiReqValid, 0);
        check("rst_resp_ready", oDmiRespReady, 0);
        check("rst_hard_reset", oDmiHardReset, 0);
        check("rst_req_fields", {oDmiReqAddr, oDmiReqData, oDmiReqOp}, 0);
        nRst = 1'b1;
        repeat (3) @(negedge iClk);

        jtag_clk(1'b0, 1'b0, t);
        scan_dr(32, 64'h0, d);
        check("idcode_after_reset", d, EXP_ID);
        check("tdo_en_idle", oTdoEn, 0);

        for (int i = 0; i < 5; i++) begin
            set_ir(vecs[i].ir);
            scan_dr(vecs[i].len, vecs[i].din, d);
            check($sformatf("vec%0d", i), d, vecs[i].dexp);
        end

        // DMI write, debug module ready after 3 cycles
        scan_dr(W, dmi(7'h10, 32'h1, 2'd2), d);
        exp_q.push_back(W'(dmi(7'h10, 32'h1, 2'd2)));
        dm_serve(3, 32'h0, 2'd0);
        sb_check("dmi_write");
        check("one_request", req_starts, 1);

        // DMI read; next scan returns the response
        scan_dr(W, dmi(7'h11, 32'h0, 2'd1), d);
        exp_q.push_back(W'(dmi(7'h11, 32'h0, 2'd1)));
        dm_serve(0, 32'hA5A5_0003, 2'd0);
        sb_check("dmi_read");
        scan_dr(W, 64'h0, d);
        check("read_capture", d, dmi(7'h11, 32'hA5A5_0003, 2'd0));

        // Scan while busy -> op 3, sticky until dmireset
        scan_dr(W, dmi(7'h12, 32'h0, 2'd1), d);
        exp_q.push_back(W'(dmi(7'h12, 32'h0, 2'd1)));
        repeat (5) @(negedge iClk);
        check("req_pending", oDmiReqValid, 1);
        scan_dr(W, 64'h0, d);
        check("busy_capture", d, dmi(7'h12, 32'hA5A5_0003, 2'd3));
        dm_serve(0, 32'h1234, 2'd0);
        sb_check("dmi_busy_req");
        rs = req_starts;
        scan_dr(W, dmi(7'h13, 32'hFF, 2'd2), d);
        check("sticky3_capture", d, dmi(7'h12, 32'h1234, 2'd3));
        repeat (10) @(negedge iClk);
        check("sticky_drops_req", req_starts, rs);
        set_ir(5'h10);
        scan_dr(32, 64'h1 << 16, d);
        check("dtmcs_stat3", d, 64'h1C71);
        scan_dr(32, 64'h0, d);
        check("dtmcs_cleared", d, 64'h1071);
        set_ir(5'h11);
        scan_dr(W, dmi(7'h14, 32'hCAFE, 2'd2), d);
        check("after_dmireset", d, dmi(7'h12, 32'h1234, 2'd0));
        exp_q.push_back(W'(dmi(7'h14, 32'hCAFE, 2'd2)));
        dm_serve(1, 32'h0, 2'd0);
        sb_check("dmi_write2");

        // Failed response -> sticky 2, cleared by dmihardreset
        scan_dr(W, dmi(7'h15, 32'h0, 2'd1), d);
        check("pre_fail_capture", d, dmi(7'h14, 32'h0, 2'd0));
        exp_q.push_back(W'(dmi(7'h15, 32'h0, 2'd1)));
        dm_serve(0, 32'hDEAD, 2'd2);
        sb_check("dmi_fail_req");
        scan_dr(W, 64'h0, d);
        check("fail_capture", d, dmi(7'h15, 32'hDEAD, 2'd2));
        set_ir(5'h10);
        scan_dr(32, 64'h1 << 17, d);
        check("dtmcs_stat2", d, 64'h1871);
        check("hard_reset_pulse", hr_cnt, 1);
        scan_dr(32, 64'h0, d);
        check("dtmcs_after_hard", d, 64'h1071);

        // Hard reset aborts an outstanding request
        set_ir(5'h11);
        scan_dr(W, dmi(7'h16, 32'h0, 2'd1), d);
        check("abort_pre_capture", d, dmi(7'h15, 32'hDEAD, 2'd0));
        repeat (5) @(negedge iClk);
        check("abort_pending", oDmiReqValid, 1);
        set_ir(5'h10);
        scan_dr(32, 64'h1 << 17, d);
        check("abort_dtmcs", d, 64'h1071);
        check("abort_valid_low", oDmiReqValid, 0);
        check("hard_reset_pulse2", hr_cnt, 2);
        set_ir(5'h11);
        scan_dr(W, 64'h0, d);
        check("abort_capture", d, dmi(7'h16, 32'hDEAD, 2'd0));

        // TRST mid-transaction: TAP resets, request still completes
        scan_dr(W, dmi(7'h17, 32'h55, 2'd2), d);
        exp_q.push_back(W'(dmi(7'h17, 32'h55, 2'd2)));
        iTrstn = 1'b0;
        #100;
        iTrstn = 1'b1;
        dm_serve(2, 32'h0, 2'd0);
        sb_check("trst_write");
        jtag_clk(1'b0, 1'b0, t);
        scan_dr(32, 64'h0, d);
        check("idcode_after_trst", d, EXP_ID);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
